// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master behind a cmd/rsp handshake port,
// with an optional B/R response timeout.
module axi_lite_master #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t r_state;
  logic r_cmd_ready, r_rsp_valid, r_timeout;
  logic r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [1:0] r_resp;
  logic [3:0] r_wstrb;
  logic [CW-1:0] r_cnt;
  logic w_aw_ok, w_w_ok, w_hs, w_expire;
  assign w_aw_ok = !r_awvalid || awready;
  assign w_w_ok = !r_wvalid || wready;
  assign w_hs = (bvalid && r_bready) || (rvalid && r_rready);
  // The last counted cycle is TIMEOUT_CYC-1, so ready is high for exactly TIMEOUT_CYC cycles
  assign w_expire = (TIMEOUT_CYC != 0) && (r_cnt == LAST);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_timeout <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_bready <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready <= 1'b0;
      r_rdata <= '0;
      r_resp <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_cnt <= '0;
    end else
      case (r_state)
        IDLE:
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_addr <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_wstrb <= cmd_wstrb;
            r_awvalid <= cmd_write;
            r_wvalid <= cmd_write;
            r_arvalid <= !cmd_write;
            r_state <= cmd_write ? WR_REQ : RD_REQ;
          end else r_cmd_ready <= 1'b1;
        WR_REQ: begin
          if (awready) r_awvalid <= 1'b0;
          if (wready) r_wvalid <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_cnt <= '0;
            r_state <= WR_RESP;
          end
        end
        RD_REQ:
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready <= 1'b1;
            r_cnt <= '0;
            r_state <= RD_DATA;
          end
        WR_RESP, RD_DATA:
          if (w_hs || w_expire) begin
            r_bready <= 1'b0;
            r_rready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_timeout <= !w_hs;
            r_resp <= !w_hs ? 2'b10 : r_rready ? rresp : bresp;
            r_rdata <= (w_hs && r_rready) ? rdata : '0;
            r_state <= RSP;
          end else r_cnt <= r_cnt + 1'b1;
        RSP:
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_resp = r_resp;
  assign rsp_timeout = r_timeout;
  assign awaddr = r_addr;
  assign araddr = r_addr;
  assign awprot = 3'b000;
  assign arprot = 3'b000;
  assign awvalid = r_awvalid;
  assign wvalid = r_wvalid;
  assign wdata = r_wdata;
  assign wstrb = r_wstrb;
  assign bready = r_bready;
  assign arvalid = r_arvalid;
  assign rready = r_rready;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized transactions against a behavioural slave and response model.
module tb_axi_lite_master;
  localparam int TO = 4;
  logic clk = 0;
  logic reset_n = 0;
  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata, awaddr, wdata, araddr;
  logic [1:0] rsp_resp;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  axi_lite_master #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // One full command/response exchange; the slave waits a_dly/w_dly cycles before its address/data
  // ready and raises bvalid/rvalid r_dly cycles after the request phase completes.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int a_dly, input int w_dly, input int r_dly,
                         input logic [1:0] code, input logic [31:0] rd, input int hold);
    logic to, aw_done, w_done, resp_taken, fin, bad_axi, bad_cmd, bad_rsp;
    logic [34:0] r0;
    int n_cmd, aw_w, w_w, done_at, rsp_at, ack_at, nb, nr, m;
    to = (r_dly >= TO);
    m = wr ? ((a_dly > w_dly) ? a_dly : w_dly) : a_dly;
    {aw_done, w_done, resp_taken, fin, bad_axi, bad_cmd, bad_rsp} = '0;
    r0 = '0;
    n_cmd = -1; done_at = -1; rsp_at = -1; ack_at = -1;
    aw_w = 0; w_w = 0; nb = 0; nr = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = code; rresp = code; rdata = rd; rsp_ready = 1;
    for (int c = 0; c < 80 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (n_cmd < 0) begin
        if (cmd_ready) n_cmd = c;
      end else if (ack_at >= 0) begin
        check("cmd_ready_after_rsp", cmd_ready, 1);
        check("rsp_valid_after_rsp", rsp_valid, 0);
        fin = 1;
      end else begin
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
        if (cmd_ready) bad_cmd = 1;
        if (c == n_cmd + 1) check("valid_rise", {awvalid, wvalid, arvalid}, wr ? 3'b110 : 3'b001);
        if (wr) begin
          if (aw_done == awvalid || w_done == wvalid || arvalid) bad_axi = 1;
          if (wvalid && (wdata !== wd || wstrb !== st)) bad_axi = 1;
          if (awvalid && awaddr !== addr) bad_axi = 1;
          awready = awvalid && !aw_done && aw_w >= a_dly;
          wready = wvalid && !w_done && w_w >= w_dly;
          if (awready) begin
            aw_done = 1; check("awaddr", awaddr, addr); check("awprot", {29'b0, awprot}, 0);
          end else if (awvalid) aw_w++;
          if (wready) begin
            w_done = 1; check("wdata", wdata, wd); check("wstrb", {28'b0, wstrb}, {28'b0, st});
          end else if (wvalid) w_w++;
          if (aw_done && w_done && done_at < 0) done_at = c;
          bvalid = done_at >= 0 && c >= done_at + 1 + r_dly && !resp_taken;
          if (bready) nr++;
          if (bvalid && bready) begin nb++; resp_taken = 1; end
        end else begin
          if (aw_done == arvalid || awvalid || wvalid) bad_axi = 1;
          if (arvalid && araddr !== addr) bad_axi = 1;
          arready = arvalid && !aw_done && aw_w >= a_dly;
          if (arready) begin
            aw_done = 1; done_at = c;
            check("araddr", araddr, addr); check("arprot", {29'b0, arprot}, 0);
          end else if (arvalid) aw_w++;
          rvalid = done_at >= 0 && c >= done_at + 1 + r_dly && !resp_taken;
          if (rready) nr++;
          if (rvalid && rready) begin nb++; resp_taken = 1; end
        end
        if (rsp_valid) begin
          if (rsp_at < 0) begin rsp_at = c; r0 = {rsp_rdata, rsp_resp, rsp_timeout}; end
          if ({rsp_rdata, rsp_resp, rsp_timeout} !== r0) bad_rsp = 1;
          rsp_ready = (c - rsp_at >= hold);
          if (rsp_ready) begin
            check("rsp_rdata", rsp_rdata, (to || wr) ? 32'h0 : rd);
            check("rsp_resp", {30'b0, rsp_resp}, to ? 32'd2 : {30'b0, code});
            check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, to});
            ack_at = c; cmd_valid = 0;
          end
        end else rsp_ready = 1;
      end
    end
    if (!fin) check("txn_completes", 0, 1);
    check("rsp_latency", rsp_at - n_cmd, 3 + m + (to ? TO - 1 : r_dly));
    check("resp_handshakes", nb, to ? 0 : 1);
    check("ready_cycles", nr, to ? TO : r_dly + 1);
    check("axi_protocol_ok", bad_axi, 0);
    check("cmd_ready_low_busy", bad_cmd, 0);
    check("rsp_stable", bad_rsp, 0);
    {awready, wready, arready} = '0;
  endtask
  task automatic reset_mid();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h1234; cmd_wstrb = 4'h3;
    {awready, wready, bvalid, arready, rvalid} = '0;
    rsp_ready = 0;
    @(negedge clk);
    cmd_valid = 0;
    check("rst_pre_valids", {awvalid, wvalid}, 2'b11);
    #2 reset_n = 0;
    #1 check("rst_async_valids", {awvalid, wvalid, cmd_ready}, 3'b000);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    check("rst_cmd_ready_first_clk", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("rst_no_rsp", {rsp_valid, awvalid, wvalid}, 3'b000);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready,
                            rsp_timeout, rsp_resp}, 0);
    check("reset_rdata", rsp_rdata, 0);
    #2 reset_n = 1;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);
    run_txn(1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
    run_txn(0, 32'h0C, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h000000A5, 0);
    run_txn(1, 32'h10, 32'hCAFEF00D, 4'h5, 0, 3, 0, 2'b00, 32'h0, 0);
    run_txn(1, 32'h14, 32'h11112222, 4'hA, 2, 0, 1, 2'b10, 32'h0, 1);
    run_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, 9, 2'b00, 32'hFFFFFFFF, 0);
    run_txn(0, 32'h24, 32'h0, 4'h0, 1, 0, TO - 1, 2'b01, 32'h5A5A5A5A, 0);
    run_txn(1, 32'h28, 32'h33334444, 4'hF, 0, 0, TO, 2'b00, 32'h0, 0);
    run_txn(0, 32'h2C, 32'h0, 4'h0, 0, 0, 0, 2'b11, 32'h87654321, 5);
    reset_mid();
    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 6), 2'($urandom), $urandom,
              $urandom_range(0, 3));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
